// File: rtl/dsi_sched_pkg.sv
// Shared types and default command addresses for the DSI transmit scheduler.
package dsi_sched_pkg;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE,
        ST_GAP
    } sched_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INIT,
        GNT_HOST,
        GNT_VIDEO
    } grant_t;

    localparam logic [7:0] DEFAULT_VS_CMD   = 8'h00;
    localparam logic [7:0] DEFAULT_LINE_CMD = 8'h10;

endpackage

// File: rtl/dsi_init_table.sv
// Panel init command table: synchronous write, asynchronous read, contents not reset.
module dsi_init_table #(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata_c
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/dsi_tx_scheduler.sv
// Arbitrates init list, host commands and video packets onto the DSI HS transmitter.
// Define SCHED_STATS_EN to add frame and timeout statistics counters.
module dsi_tx_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int unsigned INIT_DEPTH  = 32,
    parameter int unsigned LINES       = 480,
    parameter logic [7:0]  VS_CMD      = DEFAULT_VS_CMD,
    parameter logic [7:0]  LINE_CMD    = DEFAULT_LINE_CMD,
    parameter int unsigned LP_GAP      = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                          byte_clock_o,
    input  logic                          reset_i,
    input  logic                          cfg_we_i,
    input  logic [$clog2(INIT_DEPTH)-1:0] cfg_addr_i,
    input  logic [7:0]                    cfg_data_i,
    input  logic [$clog2(INIT_DEPTH):0]   init_len_i,
    input  logic                          init_start_i,
    input  logic                          host_req_i,
    input  logic [7:0]                    host_cmd_i,
    output logic                          host_ack_o,
    input  logic                          video_en_i,
    input  logic                          line_ready_i,
    input  logic                          finish_i,
    output logic                          write_cmd_o,
    output logic [7:0]                    command_o,
    output logic                          busy_o,
    output logic                          init_done_o,
    output logic                          frame_start_o,
`ifdef SCHED_STATS_EN
    output logic [15:0]                   frame_count_o,
    output logic [7:0]                    timeout_count_o,
`endif
    output logic                          timeout_o
);

    localparam int unsigned AW      = $clog2(INIT_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned LW      = $clog2(LINES + 1);
    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > LP_GAP) ? ACK_TIMEOUT : LP_GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    sched_state_t  state, state_nxt;
    grant_t        grant, win_c;
    logic [PW-1:0] init_ptr;
    logic          init_active;
    logic          start_pend;
    logic [LW-1:0] line_cnt;
    logic [CW-1:0] cnt;
    logic [7:0]    table_rdata_c;
    logic [7:0]    win_cmd_c;
    logic          init_req_c, video_req_c;
    logic          ack_expired_c, gap_done_c;
    logic          start_apply_c, timeout_event_c, frame_event_c;

    dsi_init_table #(
        .DEPTH (INIT_DEPTH)
    ) u_init_table (
        .clk     (byte_clock_o),
        .we      (cfg_we_i),
        .waddr   (cfg_addr_i),
        .wdata   (cfg_data_i),
        .raddr   (init_ptr[AW-1:0]),
        .rdata_c (table_rdata_c)
    );

    // Fixed-priority winner: init list, then host, then video
    always_comb begin
        init_req_c  = init_active && (init_ptr < init_len_i);
        video_req_c = video_en_i && ((line_cnt == '0) || line_ready_i);
        win_c       = GNT_NONE;
        win_cmd_c   = '0;
        if (init_req_c) begin
            win_c     = GNT_INIT;
            win_cmd_c = table_rdata_c;
        end else if (host_req_i) begin
            win_c     = GNT_HOST;
            win_cmd_c = host_cmd_i;
        end else if (video_req_c) begin
            win_c     = GNT_VIDEO;
            win_cmd_c = (line_cnt == '0) ? VS_CMD : LINE_CMD;
        end
    end

    assign ack_expired_c   = (cnt == CW'(ACK_TIMEOUT - 1));
    assign gap_done_c      = (cnt == CW'(LP_GAP - 1));
    assign timeout_event_c = (state == ST_ISSUE) && finish_i && ack_expired_c;
    assign frame_event_c   = (state == ST_RELEASE) && (grant == GNT_VIDEO) && (line_cnt == '0);
    // A restart never lands on a cycle that is issuing or completing a command
    assign start_apply_c   = (init_start_i || start_pend) &&
                             ((state == ST_GAP) || ((state == ST_ARB) && (win_c == GNT_NONE)));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:     if (win_c != GNT_NONE) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!finish_i) begin
                    state_nxt = ST_BUSY;
                end else if (ack_expired_c) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_BUSY:    if (finish_i) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_GAP;
            ST_GAP:     if (gap_done_c) state_nxt = ST_ARB;
            default:    state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge byte_clock_o or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_ARB;
            grant         <= GNT_NONE;
            cnt           <= '0;
            init_ptr      <= '0;
            init_active   <= 1'b0;
            start_pend    <= 1'b0;
            line_cnt      <= '0;
            write_cmd_o   <= 1'b0;
            command_o     <= '0;
            busy_o        <= 1'b0;
            init_done_o   <= 1'b0;
            host_ack_o    <= 1'b0;
            frame_start_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= (state_nxt == state) ? cnt + CW'(1) : '0;
            write_cmd_o   <= (state_nxt == ST_ISSUE) || (state_nxt == ST_BUSY);
            busy_o        <= (state_nxt != ST_ARB);
            host_ack_o    <= (state == ST_RELEASE) && (grant == GNT_HOST);
            frame_start_o <= frame_event_c;

            if ((state == ST_ARB) && (win_c != GNT_NONE)) begin
                grant     <= win_c;
                command_o <= win_cmd_c;
            end
            if ((state == ST_ARB) && !video_en_i) begin
                line_cnt <= '0;
            end
            if (timeout_event_c) begin
                timeout_o <= 1'b1;
                grant     <= GNT_NONE;
            end

            if (state == ST_RELEASE) begin
                grant <= GNT_NONE;
                if (grant == GNT_INIT) begin
                    init_ptr <= init_ptr + PW'(1);
                end
                if (grant == GNT_VIDEO) begin
                    line_cnt <= (line_cnt == LW'(LINES)) ? '0 : line_cnt + LW'(1);
                end
            end

            if (start_apply_c) begin
                init_active <= 1'b1;
                init_ptr    <= '0;
                init_done_o <= 1'b0;
                start_pend  <= 1'b0;
            end else begin
                if (init_start_i) begin
                    start_pend <= 1'b1;
                end
                if (init_active && (init_ptr >= init_len_i)) begin
                    init_active <= 1'b0;
                    init_done_o <= 1'b1;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    // Frame counter wraps; timeout counter saturates
    always_ff @(posedge byte_clock_o or posedge reset_i) begin
        if (reset_i) begin
            frame_count_o   <= '0;
            timeout_count_o <= '0;
        end else begin
            if (frame_event_c) begin
                frame_count_o <= frame_count_o + 16'd1;
            end
            if (timeout_event_c && (timeout_count_o != 8'hFF)) begin
                timeout_count_o <= timeout_count_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsi_tx_scheduler.sv
// Scoreboard bench for dsi_tx_scheduler with a behavioural transmitter model.
module tb_dsi_tx_scheduler;

    localparam int INIT_DEPTH  = 32;
    localparam int LINES       = 2;
    localparam int LP_GAP      = 4;
    localparam int ACK_TIMEOUT = 64;
    localparam int AW          = $clog2(INIT_DEPTH);
    localparam int LENW        = AW + 1;
    localparam logic [7:0] VS_CMD   = 8'h00;
    localparam logic [7:0] LINE_CMD = 8'h10;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            cfg_we = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [7:0]      cfg_data = '0;
    logic [LENW-1:0] init_len = '0;
    logic            init_start = 1'b0;
    logic            host_req = 1'b0;
    logic [7:0]      host_cmd = '0;
    logic            host_ack;
    logic            video_en = 1'b0;
    logic            line_ready = 1'b0;
    logic            finish = 1'b1;
    logic            write_cmd;
    logic [7:0]      command;
    logic            busy;
    logic            init_done;
    logic            frame_start;
    logic            timeout;
`ifdef SCHED_STATS_EN
    logic [15:0]     frame_count;
    logic [7:0]      timeout_count;
`endif

    dsi_tx_scheduler #(
        .INIT_DEPTH  (INIT_DEPTH),
        .LINES       (LINES),
        .VS_CMD      (VS_CMD),
        .LINE_CMD    (LINE_CMD),
        .LP_GAP      (LP_GAP),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .byte_clock_o    (clk),
        .reset_i         (reset_i),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_data_i      (cfg_data),
        .init_len_i      (init_len),
        .init_start_i    (init_start),
        .host_req_i      (host_req),
        .host_cmd_i      (host_cmd),
        .host_ack_o      (host_ack),
        .video_en_i      (video_en),
        .line_ready_i    (line_ready),
        .finish_i        (finish),
        .write_cmd_o     (write_cmd),
        .command_o       (command),
        .busy_o          (busy),
        .init_done_o     (init_done),
        .frame_start_o   (frame_start),
`ifdef SCHED_STATS_EN
        .frame_count_o   (frame_count),
        .timeout_count_o (timeout_count),
`endif
        .timeout_o       (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ref_tbl [INIT_DEPTH];
    int ha_cnt = 0;
    int fs_cnt = 0;
    int ack_dly = 2;
    int fin_dly = 20;
    bit never_ack = 1'b0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the expected command on every new write_cmd, checks LP gap and stability
    initial begin
        logic       wc_prev;
        logic [7:0] held;
        bit         had_cmd;
        bit         stable;
        int         idle_cnt;
        wc_prev = 1'b0; held = '0; had_cmd = 1'b0; stable = 1'b1; idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                wc_prev = 1'b0; had_cmd = 1'b0; idle_cnt = 0;
            end else begin
                if (host_ack) ha_cnt++;
                if (frame_start) fs_cnt++;
                if (write_cmd && !wc_prev) begin
                    if (had_cmd) check("lp_gap", 32'(idle_cnt >= LP_GAP), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd actual=%0h required=none", command);
                    end else begin
                        check("command", 32'(command), 32'(exp_q.pop_front()));
                    end
                    held = command;
                    stable = 1'b1;
                end else if (write_cmd) begin
                    if (command !== held) stable = 1'b0;
                end else if (wc_prev) begin
                    check("cmd_stable", 32'(stable), 32'd1);
                    had_cmd = 1'b1;
                    idle_cnt = 1;
                end else begin
                    idle_cnt++;
                end
                wc_prev = write_cmd;
            end
        end
    end

    // Transmitter: finish drops ack_dly cycles after write_cmd, rises fin_dly later
    initial begin
        forever begin
            @(negedge clk);
            if (write_cmd && !reset_i) begin
                if (!never_ack) begin
                    repeat (ack_dly - 1) @(negedge clk);
                    finish = 1'b0;
                    repeat (fin_dly) @(negedge clk);
                    finish = 1'b1;
                end
                while (write_cmd) @(negedge clk);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) line_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input int a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        ref_tbl[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int idle = 0;
        int n = 0;
        while (idle < 8 && n < budget) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !busy && !write_cmd && finish) idle++;
            else idle = 0;
        end
        check("drain", 32'(idle >= 8), 32'd1);
    endtask

    task automatic wait_fs(input int target, input int budget);
        int n = 0;
        while (fs_cnt < target && n < budget) begin @(negedge clk); n++; end
        check("frame_start_seen", 32'(fs_cnt >= target), 32'd1);
    endtask

    task automatic wait_ha(input int target, input int budget);
        int n = 0;
        while (ha_cnt < target && n < budget) begin @(negedge clk); n++; end
        check("host_ack_seen", 32'(ha_cnt >= target), 32'd1);
    endtask

    task automatic wait_wc(input int budget);
        int n = 0;
        while (!write_cmd && n < budget) begin @(negedge clk); n++; end
        check("write_cmd_seen", 32'(write_cmd), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_write_cmd"}, 32'(write_cmd), 32'd0);
        check({tag, "_command"}, 32'(command), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_host_ack"}, 32'(host_ack), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int fs0, ha0, len, n, bad;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        reset_i = 1'b0;
        @(negedge clk);

        // Directed init list
        cfg_write(0, 8'h20); cfg_write(1, 8'h30); cfg_write(2, 8'h40);
        init_len = LENW'(3);
        exp_q.push_back(8'h20); exp_q.push_back(8'h30); exp_q.push_back(8'h40);
        pulse_start();
        check("init_done_clear", 32'(init_done), 32'd0);
        wait_drain(500);
        check("init_done", 32'(init_done), 32'd1);

        // Random init lists with random transmitter latency
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) cfg_write(i, 8'($urandom));
            for (int i = 0; i < len; i++) exp_q.push_back(ref_tbl[i]);
            init_len = LENW'(len);
            ack_dly = $urandom_range(1, 6);
            fin_dly = $urandom_range(3, 24);
            pulse_start();
            check("init_done_clear_r", 32'(init_done), 32'd0);
            wait_drain(1000);
            check("init_done_r", 32'(init_done), 32'd1);
        end

        // Empty init list completes immediately
        init_len = '0;
        pulse_start();
        @(negedge clk);
        check("init_len0_done", 32'(init_done), 32'd1);
        wait_drain(100);

        // Host beats video when both request in the same arbitration
        ack_dly = 2; fin_dly = 6;
        fs0 = fs_cnt; ha0 = ha_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(VS_CMD); exp_q.push_back(LINE_CMD); exp_q.push_back(LINE_CMD);
        exp_q.push_back(VS_CMD);
        host_cmd = 8'h55; host_req = 1'b1; video_en = 1'b1; line_ready = 1'b1;
        wait_ha(ha0 + 1, 300);
        host_req = 1'b0;
        wait_fs(fs0 + 2, 800);
        video_en = 1'b0; line_ready = 1'b0;
        wait_drain(300);
        check("host_ack_count", 32'(ha_cnt - ha0), 32'd1);
        check("frame_start_count", 32'(fs_cnt - fs0), 32'd2);

        // No line ready after VS: scheduler stays idle
        fs0 = fs_cnt;
        exp_q.push_back(VS_CMD);
        video_en = 1'b1;
        wait_fs(fs0 + 1, 300);
        repeat (6) @(negedge clk);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || write_cmd) bad++;
        end
        check("idle_without_line", 32'(bad), 32'd0);

        // Disable mid-frame after one line, next frame restarts with VS
        exp_q.push_back(LINE_CMD);
        line_ready = 1'b1;
        wait_wc(100);
        line_ready = 1'b0; video_en = 1'b0;
        wait_drain(300);
        fs0 = fs_cnt;
        exp_q.push_back(VS_CMD); exp_q.push_back(LINE_CMD); exp_q.push_back(LINE_CMD);
        exp_q.push_back(VS_CMD);
        rand_ready = 1'b1; video_en = 1'b1;
        wait_fs(fs0 + 2, 3000);
        rand_ready = 1'b0; line_ready = 1'b0; video_en = 1'b0;
        wait_drain(300);

        // Random host commands; host_cmd changes after grant must not leak
        for (int it = 0; it < 4; it++) begin
            ha0 = ha_cnt;
            ack_dly = $urandom_range(1, 6);
            fin_dly = $urandom_range(3, 24);
            host_cmd = 8'($urandom);
            exp_q.push_back(host_cmd);
            host_req = 1'b1;
            wait_wc(50);
            host_cmd = ~host_cmd;
            wait_ha(ha0 + 1, 200);
            host_req = 1'b0;
            wait_drain(200);
            check("host_ack_once", 32'(ha_cnt - ha0), 32'd1);
        end

        // Accept timeout: entry is retried after the abort
        v = 8'($urandom);
        cfg_write(0, v);
        init_len = LENW'(1);
        never_ack = 1'b1;
        exp_q.push_back(v);
        pulse_start();
        wait_wc(50);
        n = 0;
        while (write_cmd && n < 200) begin @(negedge clk); n++; end
        check("timeout_len", 32'(n), 32'(ACK_TIMEOUT));
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_no_done", 32'(init_done), 32'd0);
        never_ack = 1'b0;
        ack_dly = 2; fin_dly = 10;
        exp_q.push_back(v);
        wait_drain(300);
        check("retry_done", 32'(init_done), 32'd1);
        check("timeout_sticky", 32'(timeout), 32'd1);
`ifdef SCHED_STATS_EN
        check("stat_frames", 32'(frame_count), 32'(fs_cnt));
        check("stat_timeouts", 32'(timeout_count), 32'd1);
`endif

        // Reset during BUSY
        fin_dly = 30;
        host_cmd = 8'h81;
        exp_q.push_back(host_cmd);
        host_req = 1'b1;
        n = 0;
        while (finish && n < 100) begin @(negedge clk); n++; end
        check("reach_busy", 32'(!finish), 32'd1);
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check_outputs_zero("busy_rst");
        host_req = 1'b0;
        exp_q.delete();
        n = 0;
        while (!finish && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        reset_i = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (write_cmd || busy) bad++;
        end
        check("post_reset_quiet", 32'(bad), 32'd0);
`ifdef SCHED_STATS_EN
        check("stat_reset", 32'(frame_count), 32'd0);
`endif

        // Normal operation resumes after reset
        ha0 = ha_cnt;
        fin_dly = 8;
        host_cmd = 8'h3C;
        exp_q.push_back(host_cmd);
        host_req = 1'b1;
        wait_ha(ha0 + 1, 200);
        host_req = 1'b0;
        wait_drain(200);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
